// File: rtl/mem_access_seq.sv
// mem_access_seq: breaks one CPU load/store of 1, 2, 4 or 8 bytes into single-byte cycles on a
// byte-wide memory port with a 1-cycle registered read. Memory order is big-endian: the lowest
// address holds the most significant byte.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   req              request strobe, accepted only while ready=1
//   write            1=store, 0=load
//   size             0=1B, 1=2B, 2=4B, 3=8B
//   sext             sign-extend a load result (size<3 only)
//   addr             byte base address
//   wdata            store data, right-aligned
//   ready            high in IDLE
//   done             one-cycle completion pulse
//   err              misalignment flag, valid with done
//   rdata            load result, right-aligned
//   mem_addr         byte address to memory
//   mem_write        byte write enable to memory
//   mem_data_in      byte written to memory
//   mem_data_out     byte read from memory, valid the cycle after mem_addr
module mem_access_seq #(
   parameter int unsigned ADDR_W = 15,
   parameter int unsigned DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              write,
   input  logic [1:0]        size,
   input  logic              sext,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              done,
   output logic              err,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_write,
   output logic [7:0]        mem_data_in,
   input  logic [7:0]        mem_data_out
);

   typedef enum logic [1:0] {StIdle, StLoad, StStore} state_e;

   state_e              state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [1:0]          size_q, size_d;
   logic                sext_q, sext_d;
   logic [DATA_W-1:0]   sreg_q, sreg_d;
   logic [DATA_W-1:0]   acc_q, acc_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [3:0]          n_q;
   logic                misaligned;
   logic [DATA_W-1:0]   acc_shift;

   // Zero- or sign-extend the low 8N bits of an accumulated load.
   function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] sz, input logic sx);
      logic [DATA_W-1:0] r;
      unique case (sz)
         2'd0:    r = {{56{sx & v[7]}},  v[7:0]};
         2'd1:    r = {{48{sx & v[15]}}, v[15:0]};
         2'd2:    r = {{32{sx & v[31]}}, v[31:0]};
         default: r = v;
      endcase
      return r;
   endfunction

   assign n_q       = 4'd1 << size_q;
   assign acc_shift = {acc_q[DATA_W-9:0], mem_data_out};

   always_comb begin
      unique case (size)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = addr[0];
         2'd2:    misaligned = |addr[1:0];
         default: misaligned = |addr[2:0];
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      base_d  = base_q;
      size_d  = size_q;
      sext_d  = sext_q;
      sreg_d  = sreg_q;
      acc_d   = acc_q;
      done_d  = 1'b0;
      err_d   = err_q;
      rdata_d = rdata_q;

      unique case (state_q)
         StIdle: begin
            if (req) begin
               if (misaligned) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
               end else begin
                  base_d = addr;
                  size_d = size;
                  cnt_d  = 4'd0;
                  if (write) begin
                     // Left-justify so the most significant used byte leaves first.
                     unique case (size)
                        2'd0:    sreg_d = wdata << 56;
                        2'd1:    sreg_d = wdata << 48;
                        2'd2:    sreg_d = wdata << 32;
                        default: sreg_d = wdata;
                     endcase
                     state_d = StStore;
                  end else begin
                     sext_d  = sext;
                     acc_d   = '0;
                     state_d = StLoad;
                  end
               end
            end
         end

         StLoad: begin
            // Byte requested at cnt-1 arrives now.
            if (cnt_q != 4'd0) acc_d = acc_shift;
            if (cnt_q == n_q) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               done_d  = 1'b1;
               err_d   = 1'b0;
               rdata_d = extend(acc_shift, size_q, sext_q);
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         StStore: begin
            sreg_d = sreg_q << 8;
            if (cnt_q == n_q - 4'd1) begin
               state_d = StIdle;
               cnt_d   = 4'd0;
               done_d  = 1'b1;
               err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         base_q  <= '0;
         size_q  <= 2'd0;
         sext_q  <= 1'b0;
         sreg_q  <= '0;
         acc_q   <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         base_q  <= base_d;
         size_q  <= size_d;
         sext_q  <= sext_d;
         sreg_q  <= sreg_d;
         acc_q   <= acc_d;
         done_q  <= done_d;
         err_q   <= err_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      mem_addr    = '0;
      mem_write   = 1'b0;
      mem_data_in = 8'd0;
      if (state_q == StStore) begin
         mem_addr    = base_q + ADDR_W'(cnt_q);
         mem_write   = 1'b1;
         mem_data_in = sreg_q[DATA_W-1 -: 8];
      end else if (state_q == StLoad && cnt_q < n_q) begin
         mem_addr = base_q + ADDR_W'(cnt_q);
      end
   end

   assign ready = (state_q == StIdle);
   assign done  = done_q;
   assign err   = err_q;
   assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_access_seq.sv
module tb_mem_access_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req, write, sext;
   logic [1:0]  size;
   logic [14:0] addr;
   logic [63:0] wdata;
   logic        ready, done, err;
   logic [63:0] rdata;
   logic [14:0] mem_addr;
   logic        mem_write;
   logic [7:0]  mem_data_in, mem_data_out;

   mem_access_seq dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req          (req),
      .write        (write),
      .size         (size),
      .sext         (sext),
      .addr         (addr),
      .wdata        (wdata),
      .ready        (ready),
      .done         (done),
      .err          (err),
      .rdata        (rdata),
      .mem_addr     (mem_addr),
      .mem_write    (mem_write),
      .mem_data_in  (mem_data_in),
      .mem_data_out (mem_data_out)
   );

   always #5 clk = ~clk;

   // Physical byte memory with registered read, and the model's view of it.
   logic [7:0] mem [0:32767];
   logic [7:0] ref_mem [0:32767];

   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= mem_data_in;
      mem_data_out <= mem[mem_addr];
   end

   int n_checks = 0;
   int n_fail   = 0;

   // Expectations for the transaction in flight.
   int          exp_lat, exp_nwr;
   logic        exp_err;
   logic [63:0] exp_rdata = 64'd0;
   logic        cur_write, cur_mis;
   logic [14:0] cur_addr;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Present a request at a negedge and derive its expected outcome from the memory model.
   task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                        input logic [14:0] a, input logic [63:0] wd);
      int n;
      logic [63:0] v;
      n = 1 << sz;
      check("ready_before_req", {63'd0, ready}, 64'd1);
      req = 1'b1; write = w; size = sz; sext = sx; addr = a; wdata = wd;
      cur_write = w; cur_addr = a;
      cur_mis   = (int'(a) % n) != 0;
      if (cur_mis) begin
         exp_lat = 1; exp_err = 1'b1; exp_nwr = 0;
      end else if (w) begin
         exp_lat = n + 1; exp_err = 1'b0; exp_nwr = n;
         for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8*(n-1-i) +: 8];
      end else begin
         exp_lat = n + 2; exp_err = 1'b0; exp_nwr = 0;
         v = 64'd0;
         for (int i = 0; i < n; i++) v = {v[55:0], ref_mem[int'(a) + i]};
         if (sx && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
         exp_rdata = v;
      end
   endtask

   // Wait for done (bounded) and compare; returns at the negedge of the done cycle.
   task automatic finish();
      int lat, nwr;
      logic [63:0] got_w, exp_w;
      int base;
      @(negedge clk);
      req = 1'b0;
      lat = 1;
      nwr = 0;
      while (!done && lat < 20) begin
         if (mem_write) nwr++;
         @(negedge clk);
         lat++;
      end
      if (!done) begin
         check("done_timeout", 64'd0, 64'd1);
         return;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("err", {63'd0, err}, {63'd0, exp_err});
      check("rdata", rdata, exp_rdata);
      check("write_cycles", 64'(nwr), 64'(exp_nwr));
      if (cur_write && !cur_mis) begin
         base = int'(cur_addr) & ~7;
         for (int j = 0; j < 8; j++) begin
            got_w = {got_w[55:0], mem[base + j]};
            exp_w = {exp_w[55:0], ref_mem[base + j]};
         end
         check("mem_window", got_w, exp_w);
      end
   endtask

   initial begin
      logic [7:0]  b;
      logic [7:0]  old2, old3;
      logic [14:0] ra;
      rst_n = 1'b0;
      req = 1'b0; write = 1'b0; size = 2'd0; sext = 1'b0; addr = '0; wdata = '0;
      for (int i = 0; i < 32768; i++) begin
         b = 8'($urandom);
         mem[i] = b;
         ref_mem[i] = b;
      end
      repeat (3) @(negedge clk);
      check("rst_ready", {63'd0, ready}, 64'd1);
      check("rst_done", {63'd0, done}, 64'd0);
      check("rst_err", {63'd0, err}, 64'd0);
      check("rst_rdata", rdata, 64'd0);
      check("rst_mem_write", {63'd0, mem_write}, 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_data_in", 64'(mem_data_in), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // 8B store then load back.
      issue(1'b1, 2'd3, 1'b0, 15'h0010, 64'h0123456789ABCDEF);
      finish();
      @(negedge clk);
      check("done_one_cycle", {63'd0, done}, 64'd0);
      issue(1'b0, 2'd3, 1'b0, 15'h0010, 64'd0);
      finish();
      check("load8_value", rdata, 64'h0123456789ABCDEF);
      @(negedge clk);

      // 2B sign/zero extension of 0x80,0x01.
      issue(1'b1, 2'd1, 1'b0, 15'h0020, 64'h8001);
      finish();
      @(negedge clk);
      issue(1'b0, 2'd1, 1'b1, 15'h0020, 64'd0);
      finish();
      check("load2_sext", rdata, 64'hFFFFFFFFFFFF8001);
      @(negedge clk);
      issue(1'b0, 2'd1, 1'b0, 15'h0020, 64'd0);
      finish();
      check("load2_zext", rdata, 64'h0000000000008001);
      @(negedge clk);

      // Misaligned 4B store: immediate error, no write, rdata held.
      issue(1'b1, 2'd2, 1'b0, 15'h0006, 64'hDEADBEEF);
      finish();
      check("mis_rdata_held", rdata, 64'h0000000000008001);
      @(negedge clk);

      // Back-to-back: load issued in the done cycle of a 1B store.
      issue(1'b1, 2'd0, 1'b0, 15'h0030, 64'h5A);
      finish();
      issue(1'b0, 2'd0, 1'b0, 15'h0030, 64'd0);
      finish();
      check("b2b_load", rdata, 64'h5A);
      @(negedge clk);

      // Top-of-memory 8B store/load.
      issue(1'b1, 2'd3, 1'b0, 15'h7FF8, 64'hA1B2C3D4E5F60718);
      finish();
      @(negedge clk);
      issue(1'b0, 2'd3, 1'b0, 15'h7FF8, 64'd0);
      finish();
      @(negedge clk);

      // Reset after two bytes of a 4B store.
      old2 = ref_mem[16'h0042];
      old3 = ref_mem[16'h0043];
      issue(1'b1, 2'd2, 1'b0, 15'h0040, 64'hAABBCCDD);
      ref_mem[16'h0042] = old2;
      ref_mem[16'h0043] = old3;
      @(negedge clk);
      req = 1'b0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_ready", {63'd0, ready}, 64'd1);
      check("midrst_done", {63'd0, done}, 64'd0);
      check("midrst_mem_write", {63'd0, mem_write}, 64'd0);
      check("midrst_rdata", rdata, 64'd0);
      exp_rdata = 64'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("midrst_bytes", {32'd0, mem[16'h0040], mem[16'h0041], mem[16'h0042], mem[16'h0043]},
            {32'd0, 8'hAA, 8'hBB, old2, old3});

      // Randomized traffic, sometimes back-to-back.
      for (int k = 0; k < 300; k++) begin
         if ($urandom_range(0, 7) == 0) ra = 15'h7FF8 + 15'($urandom_range(0, 7));
         else ra = 15'($urandom_range(0, 63));
         issue(1'($urandom), 2'($urandom), 1'($urandom), ra, {$urandom, $urandom});
         finish();
         if ($urandom_range(0, 2) != 0) begin
            @(negedge clk);
            check("done_pulse", {63'd0, done}, 64'd0);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Access sequencer that drives the byte-wide memory port of the SPRAM byte wrapper (15-bit byte address, 8-bit data, 1-cycle registered read).
- Turns one CPU load/store request of 1, 2, 4 or 8 bytes into a sequence of single-byte memory cycles.
- Memory byte order is big-endian: the lowest address holds the most significant byte.
- Sits between the ULM CPU datapath and the byte memory.

Parameters:
- ADDR_W, 15, byte address width; matches the memory port.
- DATA_W, 64, CPU word width; fixed at 64 (8 bytes max).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request strobe; accepted only when ready=1.
- write  in  1  1=store, 0=load; sampled on acceptance.
- size  in  2  access size: 0=1B, 1=2B, 2=4B, 3=8B; sampled on acceptance.
- sext  in  1  sign-extend load result (loads only, size<3); sampled on acceptance.
- addr  in  15  byte base address; sampled on acceptance.
- wdata  in  64  store data, right-aligned (low N bytes used); sampled on acceptance.
- ready  out  1  high in IDLE; request can be accepted.
- done  out  1  one-cycle completion pulse.
- err  out  1  misalignment flag; valid with done.
- rdata  out  64  load result, right-aligned.
- mem_addr  out  15  byte address to memory.
- mem_write  out  1  byte write enable to memory.
- mem_data_in  out  8  byte written to memory.
- mem_data_out  in  8  byte read from memory; valid the cycle after mem_addr is presented.

Behaviour:
- N = 1<<size. Aligned means addr mod N == 0.
- States: IDLE, LOAD, STORE. Counter cnt, 4 bits.
- Outputs are registered except mem_addr, mem_write and mem_data_in, which decode from state, cnt and the latched request.
- Reset (async, any state) forces:
  - state=IDLE, cnt=0;
  - done=0, err=0, rdata=0;
  - mem_write=0, mem_addr=0, mem_data_in=0.
- ready = (state==IDLE).
- IDLE:
  - req=0: mem_write=0, mem_addr=0.
  - req=1 and misaligned: no memory access, stay IDLE; next cycle done=1, err=1, rdata unchanged.
  - req=1, aligned, write=0: latch addr/size/sext, clear the accumulator, go to LOAD with cnt=0.
  - req=1, aligned, write=1: latch addr/size, load shift register with wdata<<(64-8N), go to STORE with cnt=0.
- LOAD, one state cycle for each cnt=0..N:
  - cnt<N: mem_addr = base+cnt, mem_write=0.
  - cnt>=1: acc = {acc[55:0], mem_data_out}.
  - cnt==N: go to IDLE.
  - Next cycle: done=1, err=0, rdata = acc, zero-extended, or sign-extended from bit 8N-1 when sext=1 and size<3.
  - Latency: req accepted at cycle 0, done at cycle N+2.
- STORE, one state cycle for each cnt=0..N-1:
  - mem_write=1, mem_addr=base+cnt, mem_data_in = sreg[63:56]; then sreg <<= 8.
  - cnt==N-1: go to IDLE; next cycle done=1, err=0.
  - Latency: done at cycle N+1.
- mem_write is never high outside STORE.
- rdata changes only on completion of a successful load. It holds across stores and errors.
- done is exactly one cycle; err is cleared on the next done.
- A req asserted in the same cycle as done is accepted, because ready=1 in that cycle.
- req while ready=0 is ignored and not queued.
- No address wrap is possible: aligned accesses never cross the 15-bit top (e.g. addr 0x7FF8, size 3 ends at 0x7FFF).
- Reset mid-STORE may leave a partially written word; this is permitted. Reset mid-LOAD discards partial data.

Test Plan:
- Store 8B: wdata=0x0123456789ABCDEF at addr 0x0010 → bytes 0x01..0xEF written to 0x0010..0x0017 over 8 consecutive mem_write cycles; done at cycle 9.
- Load 8B from 0x0010 after the store above → rdata=0x0123456789ABCDEF, done at cycle 10, mem_write=0 throughout.
- Load 2B with sext=1 from a location holding 0x80,0x01 → rdata=0xFFFFFFFFFFFF8001; same access with sext=0 → 0x0000000000008001.
- Misaligned store: size=2, addr=0x0006 → done=1, err=1 at cycle 1, no mem_write, rdata unchanged.
- Back-to-back: new req asserted in the done cycle of a 1B store → accepted; a 1B load of the same address returns the stored byte.
- Reset asserted mid 4B store after 2 bytes → state IDLE and ready=1 immediately, done=0, only the first 2 bytes modified.
